// File: rtl/verificador_contador.sv
// verificador_contador
// Passive checker for the cascaded N-bit counter. It watches the same
// ENB/MODO/D controls the counter receives, keeps its own reference count
// (EXP) and compares the counter's Q, RCO and Paridad against it.
//
// Ports
//   CLK       clock, rising edge
//   RESET     synchronous, active-high reset
//   ENB       counter enable (shared net with the counter)
//   MODO[1:0] counter mode: 00 +1, 01 -1, 10 +3, 11 load D
//   D[N-1:0]  counter load value
//   Q[N-1:0]  observed counter value
//   RCO       observed ripple-carry out
//   Paridad   observed parity of Q
//   SYNC      high while in LOCKED
//   ERR       one-cycle pulse per detected mismatch
//   ERR_CODE  sticky mismatch mask {Paridad, RCO, Q}
//   ERR_CNT   saturating mismatch event count
//
// Build option: VERIFICADOR_RCO_CHECK_EN enables modelling and checking of
// RCO. Without it the RCO input is ignored and ERR_CODE[1] stays 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | after reset, no comparisons, waits for a load
// LOCKED   | EXP tracks the counter, outputs compared every cycle
// FAULT    | mismatch seen, no comparisons, waits for a load to relock
//
// N must be a multiple of 4 (nibble-cascaded counter).
module verificador_contador #(
  parameter int N = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ENB,
  input  logic [1:0]   MODO,
  input  logic [N-1:0] D,
  input  logic [N-1:0] Q,
  input  logic         RCO,
  input  logic         Paridad,
  output logic         SYNC,
  output logic         ERR,
  output logic [2:0]   ERR_CODE,
  output logic [7:0]   ERR_CNT
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCKED   = 2'b01,
    FAULT    = 2'b10
  } state_t;

  state_t       state;
  logic [N-1:0] exp_q;
  logic [N-1:0] exp_next;
  logic         load;
  logic [2:0]   mis;

  assign load = ENB && (MODO == 2'b11);

  always_comb begin
    exp_next = exp_q;
    if (ENB) begin
      case (MODO)
        2'b00:   exp_next = exp_q + N'(1);
        2'b01:   exp_next = exp_q - N'(1);
        2'b10:   exp_next = exp_q + N'(3);
        default: exp_next = D;
      endcase
    end
  end

`ifdef VERIFICADOR_RCO_CHECK_EN
  logic exp_rco;
  logic rco_next;

  // Carry/borrow of the step, derived from EXP without a wide adder:
  // +1 carries from all-ones, -1 borrows from zero, +3 carries when EXP
  // is one of the top three values (upper bits all ones, low pair != 00).
  always_comb begin
    rco_next = 1'b0;
    if (ENB) begin
      case (MODO)
        2'b00:   rco_next = &exp_q;
        2'b01:   rco_next = ~|exp_q;
        2'b10:   rco_next = (&exp_q[N-1:2]) && (|exp_q[1:0]);
        default: rco_next = 1'b0;
      endcase
    end
  end

  // Outside LOCKED the only step taken is a load, whose expected RCO is 0.
  always_ff @(posedge CLK) begin
    if (RESET)
      exp_rco <= 1'b0;
    else if (state == LOCKED)
      exp_rco <= rco_next;
    else
      exp_rco <= 1'b0;
  end

  assign mis[1] = (RCO != exp_rco);
`else
  logic unused_rco;
  assign unused_rco = RCO;
  assign mis[1]     = 1'b0;
`endif

  assign mis[0] = (Q != exp_q);
  assign mis[2] = (Paridad != (^Q));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= UNLOCKED;
      exp_q    <= '0;
      SYNC     <= 1'b0;
      ERR      <= 1'b0;
      ERR_CODE <= 3'b000;
      ERR_CNT  <= 8'd0;
    end else begin
      ERR <= 1'b0;
      case (state)
        UNLOCKED, FAULT: begin
          if (load) begin
            exp_q <= D;
            state <= LOCKED;
            SYNC  <= 1'b1;
          end
        end
        LOCKED: begin
          exp_q <= exp_next;
          if (|mis) begin
            ERR      <= 1'b1;
            ERR_CODE <= ERR_CODE | mis;
            if (ERR_CNT != 8'hFF)
              ERR_CNT <= ERR_CNT + 8'd1;
            // A simultaneous load resynchronises EXP, so stay locked.
            if (!load) begin
              state <= FAULT;
              SYNC  <= 1'b0;
            end
          end
        end
        default: begin
          state <= UNLOCKED;
          SYNC  <= 1'b0;
        end
      endcase
    end
  end

endmodule
